// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants, saturation limits and geometry check for the add/sub unit
`ifndef ADDSUB_PKG_SV
`define ADDSUB_PKG_SV

`define ADDSUB_CHECK_DIV(W, S) \
   if (((W) % (S)) != 0 || (S) < 1 || (S) > (W)) begin : g_div_check \
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH"); \
   end

package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Limits are returned 64 bits wide; callers size-cast to their own width.
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

`endif

// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand/result handshake bundle for the add/sub unit
interface addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_op;
   logic             in_sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_overflow;
   logic             out_cb;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_op, in_sat, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_cb
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_op, in_sat, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_cb
   );
endinterface

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational SW-bit adder slice exposing carry into and out of its MSB
module addsub_slice #(
   parameter int SW = 8
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b_eff,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout,
   output logic          c_msb_in
);
   logic [SW:0] full;

   assign full     = {1'b0, a} + {1'b0, b_eff} + {{SW{1'b0}}, cin};
   assign sum      = full[SW-1:0];
   assign cout     = full[SW];
   // Carry into the top bit recovered from the sum bit itself.
   assign c_msb_in = a[SW-1] ^ b_eff[SW-1] ^ sum[SW-1];
endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - carry-chain pipelined signed add/subtract with saturation and valid/ready
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input logic     clk,
   input logic     rst_n,
   addsub_if.slave bus
);
   localparam int SW = WIDTH / STAGES;
   localparam int L  = STAGES - 1;
   localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;
   localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

   `ADDSUB_CHECK_DIV(WIDTH, STAGES)

   logic             advance;
   logic             st_valid [STAGES];
   logic             st_op    [STAGES];
   logic             st_sat   [STAGES];
   logic             st_c     [STAGES];
   logic [WIDTH-1:0] st_a     [STAGES];
   logic [WIDTH-1:0] st_b     [STAGES];
   logic [WIDTH-1:0] st_res   [STAGES];
   logic [WIDTH-1:0] nx_res   [STAGES];
   logic [SW-1:0]    sl_sum   [STAGES];
   logic             sl_cout  [STAGES];
   logic             sl_cmsb  [STAGES];

   // rg_*[k] holds the output of stage k, feeding stage k+1.
   logic             rg_valid [NR];
   logic             rg_op    [NR];
   logic             rg_sat   [NR];
   logic             rg_c     [NR];
   logic [WIDTH-1:0] rg_a     [NR];
   logic [WIDTH-1:0] rg_b     [NR];
   logic [WIDTH-1:0] rg_res   [NR];

   logic             fin_ovf;
   logic             fin_cb;
   logic [WIDTH-1:0] fin_res;

   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = advance;

   always_comb begin
      st_valid[0] = bus.in_valid;
      st_op[0]    = bus.in_op;
      st_sat[0]   = bus.in_sat;
      st_a[0]     = bus.in_a;
      // Subtract as a + ~b + !borrow so every slice is a plain adder.
      st_b[0]     = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
      st_c[0]     = (bus.in_op == OP_SUB) ? ~bus.in_cin : bus.in_cin;
      st_res[0]   = '0;
      for (int k = 1; k < STAGES; k++) begin
         st_valid[k] = rg_valid[k-1];
         st_op[k]    = rg_op[k-1];
         st_sat[k]   = rg_sat[k-1];
         st_c[k]     = rg_c[k-1];
         st_a[k]     = rg_a[k-1];
         st_b[k]     = rg_b[k-1];
         st_res[k]   = rg_res[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         nx_res[k]             = st_res[k];
         nx_res[k][k*SW +: SW] = sl_sum[k];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      addsub_slice #(.SW(SW)) u_slice (
         .a        (st_a[k][k*SW +: SW]),
         .b_eff    (st_b[k][k*SW +: SW]),
         .cin      (st_c[k]),
         .sum      (sl_sum[k]),
         .cout     (sl_cout[k]),
         .c_msb_in (sl_cmsb[k])
      );
   end

   // On overflow the true result always has the sign of a.
   always_comb begin
      fin_ovf = sl_cout[L] ^ sl_cmsb[L];
      fin_cb  = (st_op[L] == OP_SUB) ? ~sl_cout[L] : sl_cout[L];
      fin_res = nx_res[L];
      if (st_sat[L] && fin_ovf) begin
         fin_res = st_a[L][WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NR; k++) begin
            rg_valid[k] <= 1'b0;
            rg_op[k]    <= 1'b0;
            rg_sat[k]   <= 1'b0;
            rg_c[k]     <= 1'b0;
            rg_a[k]     <= '0;
            rg_b[k]     <= '0;
            rg_res[k]   <= '0;
         end
         bus.out_valid    <= 1'b0;
         bus.out_result   <= '0;
         bus.out_overflow <= 1'b0;
         bus.out_cb       <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES - 1; k++) begin
            rg_valid[k] <= st_valid[k];
            rg_op[k]    <= st_op[k];
            rg_sat[k]   <= st_sat[k];
            rg_c[k]     <= sl_cout[k];
            rg_a[k]     <= st_a[k];
            rg_b[k]     <= st_b[k];
            rg_res[k]   <= nx_res[k];
         end
         bus.out_valid    <= st_valid[L];
         bus.out_result   <= fin_res;
         bus.out_overflow <= fin_ovf;
         bus.out_cb       <= fin_cb;
      end
   end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub: directed corners plus random sweeps
module tb_pipelined_addsub;
   typedef struct packed {
      logic [63:0] res;
      logic        ovf;
      logic        cb;
   } exp_t;

   localparam int NCFG  = 5;
   localparam int NRAND = 1500;
   localparam int CFG_W [NCFG] = '{16, 16, 16, 32, 32};
   localparam int CFG_S [NCFG] = '{1, 4, 16, 2, 8};

   logic clk = 1'b0;
   logic rst_n;
   logic d_rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   rand_done = 0;
   int   d_pops = 0;
   exp_t dq[$];

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic op, input logic sat);
      longint      sa, sb, t, mx, mn, ci;
      logic [63:0] mask;
      exp_t        e;
      mask = (64'd1 << w) - 64'd1;
      sa   = longint'(a << (64 - w)) >>> (64 - w);
      sb   = longint'(b << (64 - w)) >>> (64 - w);
      ci   = longint'({63'd0, cin});
      t    = op ? (sa - sb - ci) : (sa + sb + ci);
      mx   = (longint'(1) <<< (w - 1)) - 1;
      mn   = -mx - 1;
      e.ovf = (t > mx) || (t < mn);
      if (op) e.cb = (a < (b + {63'd0, cin}));
      else    e.cb = ((a + b + {63'd0, cin}) >= (64'd1 << w));
      if (sat && e.ovf) e.res = 64'((t > 0) ? mx : mn) & mask;
      else              e.res = 64'(t) & mask;
      return e;
   endfunction

   addsub_if #(.WIDTH(16)) d_if ();
   pipelined_addsub #(.WIDTH(16), .STAGES(2)) u_dut (
      .clk   (clk),
      .rst_n (d_rst_n),
      .bus   (d_if)
   );

   always @(negedge clk) begin
      if (d_rst_n && d_if.out_valid && d_if.out_ready) begin
         if (dq.size() == 0) begin
            check_eq("dir_extra_beat", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = dq.pop_front();
            check_eq("dir_result", {48'd0, d_if.out_result}, e.res);
            check_eq("dir_ovf", {63'd0, d_if.out_overflow}, {63'd0, e.ovf});
            check_eq("dir_cb", {63'd0, d_if.out_cb}, {63'd0, e.cb});
         end
         d_pops++;
      end
   end

   task automatic send_d(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic op, input logic sat, input logic [15:0] er,
                         input logic eo, input logic ec);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      d_if.in_a = a; d_if.in_b = b; d_if.in_cin = cin; d_if.in_op = op; d_if.in_sat = sat;
      d_if.in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = d_if.in_ready;
         if (acc) dq.push_back('{res: {48'd0, er}, ovf: eo, cb: ec});
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
      d_if.in_valid = 1'b0;
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_rand
      localparam int W = CFG_W[g];
      localparam int S = CFG_S[g];
      addsub_if #(.WIDTH(W)) r_if ();
      pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (r_if)
      );
      exp_t q[$];

      function automatic logic [63:0] pick(input logic [63:0] mask);
         case ($urandom_range(0, 7))
            0:       return mask >> 1;
            1:       return (mask >> 1) + 64'd1;
            2:       return 64'd0;
            3:       return mask;
            default: return {$urandom, $urandom} & mask;
         endcase
      endfunction

      initial begin
         int          sent, got, cyc;
         logic [63:0] mask;
         exp_t        e;
         string       tag;
         sent = 0; got = 0; cyc = 0;
         mask = (64'd1 << W) - 64'd1;
         tag  = $sformatf("rand_w%0d_s%0d", W, S);
         r_if.in_valid = 1'b0; r_if.in_a = '0; r_if.in_b = '0;
         r_if.in_cin = 1'b0; r_if.in_op = 1'b0; r_if.in_sat = 1'b0; r_if.out_ready = 1'b0;
         @(posedge rst_n);
         @(posedge clk);
         #1;
         while ((sent < NRAND || q.size() > 0) && cyc < 20000) begin
            if (sent < NRAND) begin
               r_if.in_valid  = ($urandom_range(0, 3) != 0);
               r_if.in_a      = W'(pick(mask));
               r_if.in_b      = W'(pick(mask));
               r_if.in_cin    = 1'($urandom);
               r_if.in_op     = 1'($urandom);
               r_if.in_sat    = 1'($urandom);
               r_if.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
               r_if.in_valid  = 1'b0;
               r_if.out_ready = 1'b1;
            end
            @(negedge clk);
            if (r_if.out_valid && r_if.out_ready) begin
               if (q.size() == 0) begin
                  check_eq({tag, "_extra_beat"}, 64'd1, 64'd0);
               end else begin
                  e = q.pop_front();
                  check_eq({tag, "_result"}, 64'(r_if.out_result), e.res);
                  check_eq({tag, "_ovf"}, {63'd0, r_if.out_overflow}, {63'd0, e.ovf});
                  check_eq({tag, "_cb"}, {63'd0, r_if.out_cb}, {63'd0, e.cb});
                  got++;
               end
            end
            if (r_if.in_valid && r_if.in_ready) begin
               q.push_back(model(W, 64'(r_if.in_a), 64'(r_if.in_b), r_if.in_cin,
                                 r_if.in_op, r_if.in_sat));
               sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
         end
         check_eq({tag, "_beat_count"}, 64'(got), 64'(NRAND));
         check_eq({tag, "_drained"}, 64'(q.size()), 64'd0);
         rand_done++;
      end
   end

   initial begin
      int n;
      int base;
      int stale;
      rst_n   = 1'b0;
      d_rst_n = 1'b0;
      d_if.in_valid = 1'b0; d_if.in_a = '0; d_if.in_b = '0;
      d_if.in_cin = 1'b0; d_if.in_op = 1'b0; d_if.in_sat = 1'b0;
      d_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", {63'd0, d_if.out_valid}, 64'd0);
      check_eq("rst_in_ready", {63'd0, d_if.in_ready}, 64'd1);
      check_eq("rst_out_result", {48'd0, d_if.out_result}, 64'd0);
      rst_n   = 1'b1;
      d_rst_n = 1'b1;
      @(posedge clk);
      #1;

      send_d(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0);
      send_d(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
      send_d(16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
      send_d(16'h0000, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      send_d(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      send_d(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;

      send_d(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b1);
      @(negedge clk);
      check_eq("latency_cycle1", {63'd0, d_if.out_valid}, 64'd0);
      @(negedge clk);
      check_eq("latency_cycle2", {63'd0, d_if.out_valid}, 64'd1);
      repeat (3) @(posedge clk);
      #1;

      // Back-pressure: six beats with the sink stalled for three cycles.
      base = d_pops;
      d_if.out_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               send_d(16'(i * 16'h0101), 16'h0010, 1'b0, 1'b0, 1'b0,
                      16'(i * 16'h0101 + 16'h0010), 1'b0, 1'b0);
            end
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!d_if.out_valid && n < 20);
            check_eq("bp_in_ready_low", {63'd0, d_if.in_ready}, 64'd0);
            check_eq("bp_hold_first", {48'd0, d_if.out_result}, 64'h0111);
            repeat (2) begin
               @(negedge clk);
               check_eq("bp_hold_valid", {63'd0, d_if.out_valid}, 64'd1);
               check_eq("bp_hold_result", {48'd0, d_if.out_result}, 64'h0111);
            end
            @(posedge clk);
            #1;
            d_if.out_ready = 1'b1;
         end
      join
      n = 0;
      while (d_pops < base + 6 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_eq("bp_beats_out", 64'(d_pops - base), 64'd6);

      // Reset with two beats in flight.
      send_d(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      send_d(16'h4321, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h4320, 1'b0, 1'b0);
      d_rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", {63'd0, d_if.out_valid}, 64'd0);
      check_eq("midrst_out_result", {48'd0, d_if.out_result}, 64'd0);
      check_eq("midrst_ovf_cb", {62'd0, d_if.out_overflow, d_if.out_cb}, 64'd0);
      check_eq("midrst_in_ready", {63'd0, d_if.in_ready}, 64'd1);
      dq.delete();
      repeat (2) @(posedge clk);
      #1;
      d_rst_n = 1'b1;
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (d_if.out_valid) stale++;
      end
      check_eq("midrst_no_stale", 64'(stale), 64'd0);

      n = 0;
      while (rand_done < NCFG && n < 30000) begin
         @(posedge clk);
         n++;
      end
      check_eq("rand_all_done", 64'(rand_done), 64'(NCFG));
      check_eq("dir_queue_empty", 64'(dq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
